rs75_encoder: RTL

Systematic Reed-Solomon RS(7,5) encoder over GF(8) that accepts a stream of 5 message symbols and emits a 7-symbol codeword: the message symbols unchanged, then 2 parity symbols. It sits directly upstream of the channel/decoder path. It consumes the same GF(8) symbol encoding as the existing Symbol_Lookup/Index_Lookup tables and uses them for its constant multiplications. Both sides use a valid/ready handshake with a single registered output stage.

---
 rtl/rs75_pkg.sv | 53 +++++
 rtl/gf8_const_mul.sv | 23 ++
 rtl/rs75_encoder.sv | 119 +++++++++++
 3 files changed

// File: rtl/rs75_pkg.sv
// Shared GF(8) definitions for the RS(7,5) encoder: field tables, generator
// constants and the encoder state type.
package rs75_pkg;

  localparam int SYMBOL_WIDTH = 3;
  localparam int N            = 7;
  localparam int K            = 5;

  typedef enum logic [1:0] {
    MSG,
    PAR1,
    PAR2
  } state_t;

  // Index_Lookup: symbol -> log index (0 = zero element, k = alpha^(k-1))
  function automatic logic [SYMBOL_WIDTH-1:0] index_lookup(input logic [SYMBOL_WIDTH-1:0] sym);
    case (sym)
      3'b100:  return 3'd1;
      3'b010:  return 3'd2;
      3'b001:  return 3'd3;
      3'b110:  return 3'd4;
      3'b011:  return 3'd5;
      3'b111:  return 3'd6;
      3'b101:  return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  // Symbol_Lookup: log index -> symbol
  function automatic logic [SYMBOL_WIDTH-1:0] symbol_lookup(input logic [SYMBOL_WIDTH-1:0] idx);
    case (idx)
      3'd1:    return 3'b100;
      3'd2:    return 3'b010;
      3'd3:    return 3'b001;
      3'd4:    return 3'b110;
      3'd5:    return 3'b011;
      3'd6:    return 3'b111;
      3'd7:    return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  localparam logic [SYMBOL_WIDTH-1:0] G1_SYM = 3'b011;
  localparam logic [SYMBOL_WIDTH-1:0] G0_SYM = 3'b110;
  localparam logic [SYMBOL_WIDTH-1:0] G1_IDX = index_lookup(G1_SYM);
  localparam logic [SYMBOL_WIDTH-1:0] G0_IDX = index_lookup(G0_SYM);

  // Log index of the generator coefficient of x^i (i = 0 or 1)
  function automatic logic [SYMBOL_WIDTH-1:0] gen_idx(input int i);
    return (i == 1) ? G1_IDX : G0_IDX;
  endfunction

endpackage

// File: rtl/gf8_const_mul.sv
// GF(8) multiply of a symbol by a constant given as a log index, using the
// log/antilog tables with a mod-7 exponent add and a zero bypass.
module gf8_const_mul
  import rs75_pkg::*;
(
  input  logic [SYMBOL_WIDTH-1:0] sym,
  input  logic [SYMBOL_WIDTH-1:0] const_idx,
  output logic [SYMBOL_WIDTH-1:0] prod
);

  logic [SYMBOL_WIDTH-1:0] sym_idx;
  logic [SYMBOL_WIDTH:0]   exp_sum;
  logic [SYMBOL_WIDTH-1:0] exp_mod;

  always_comb begin
    sym_idx = index_lookup(sym);
    exp_sum = {1'b0, sym_idx - 3'd1} + {1'b0, const_idx - 3'd1};
    exp_mod = (exp_sum >= 4'd7) ? 3'(exp_sum - 4'd7) : exp_sum[SYMBOL_WIDTH-1:0];
    // zero has no logarithm, so it bypasses the tables
    prod    = (sym == '0) ? '0 : symbol_lookup(exp_mod + 3'd1);
  end

endmodule

// File: rtl/rs75_encoder.sv
// Systematic RS(7,5) encoder over GF(8): forwards 5 message symbols, then
// emits the 2 parity symbols held in the division LFSR.
module rs75_encoder
  import rs75_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SYMBOL_WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [SYMBOL_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_parity,
  output logic                    out_last
);

  localparam int NPAR = N - K;
  localparam int CW   = $clog2(K + 1);

  state_t                  state_reg, state_next;
  logic [CW-1:0]           count_reg, count_next;
  logic [SYMBOL_WIDTH-1:0] r1_reg, r1_next;
  logic [SYMBOL_WIDTH-1:0] r0_reg, r0_next;
  logic [SYMBOL_WIDTH-1:0] fb;
  logic [SYMBOL_WIDTH-1:0] prod [NPAR];
  logic                    out_free;
  logic                    accept;
  logic                    load;
  logic [SYMBOL_WIDTH-1:0] data_next;
  logic                    parity_next;
  logic                    last_next;

  assign fb = in_data ^ r1_reg;

  generate
    for (genvar gi = 0; gi < NPAR; gi++) begin : g_mul
      gf8_const_mul u_mul (
        .sym       (fb),
        .const_idx (gen_idx(gi)),
        .prod      (prod[gi])
      );
    end
  endgenerate

  always_comb begin
    out_free    = !out_valid || out_ready;
    in_ready    = (state_reg == MSG) && out_free;
    accept      = in_valid && in_ready;
    state_next  = state_reg;
    count_next  = count_reg;
    r1_next     = r1_reg;
    r0_next     = r0_reg;
    load        = 1'b0;
    data_next   = in_data;
    parity_next = 1'b0;
    last_next   = 1'b0;
    case (state_reg)
      MSG: begin
        if (accept) begin
          load       = 1'b1;
          r1_next    = r0_reg ^ prod[1];
          r0_next    = prod[0];
          count_next = count_reg + 1'b1;
          if (count_reg == CW'(K - 1)) state_next = PAR1;
        end
      end
      PAR1: begin
        if (out_free) begin
          load        = 1'b1;
          data_next   = r1_reg;
          parity_next = 1'b1;
          state_next  = PAR2;
        end
      end
      PAR2: begin
        if (out_free) begin
          load        = 1'b1;
          data_next   = r0_reg;
          parity_next = 1'b1;
          last_next   = 1'b1;
          // clearing here lets the next block start while this symbol drains
          r1_next     = '0;
          r0_next     = '0;
          count_next  = '0;
          state_next  = MSG;
        end
      end
      default: state_next = MSG;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= MSG;
      count_reg  <= '0;
      r1_reg     <= '0;
      r0_reg     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_parity <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      r1_reg    <= r1_next;
      r0_reg    <= r0_next;
      if (load) begin
        out_valid  <= 1'b1;
        out_data   <= data_next;
        out_parity <= parity_next;
        out_last   <= last_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
